// File: rtl/aia_pkg.sv
// Shared types and helpers for the AIA interrupt-file claim controller.
package aia_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPresent,
    StClaim
  } state_e;

  localparam int unsigned M_FILE  = 0;
  localparam int unsigned S_FILE  = 1;
  localparam int unsigned VS_BASE = 2;

  function automatic int unsigned file_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Priority class of a file index: 0 = M, 1 = S, 2 = any VS (lower is higher priority).
  function automatic logic [1:0] file_class(int unsigned f);
    if (f == M_FILE) return 2'd0;
    if (f == S_FILE) return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/aia_vs_rr_sel.sv
// Round-robin pick among the VS interrupt files, starting the search at ptr.
module aia_vs_rr_sel
  import aia_pkg::*;
#(
  parameter int unsigned NrVS = 2,
  parameter int unsigned PtrW = file_w(NrVS)
) (
  input  logic [NrVS-1:0] vs_elig,
  input  logic [PtrW-1:0] ptr,
  output logic            pick_valid,
  output logic [PtrW-1:0] pick_idx
);

  logic [PtrW-1:0] cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NrVS; i++) begin
      cand = PtrW'((32'(ptr) + i) % NrVS);
      if (!pick_valid && vs_elig[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/aia_intp_file_claim_ctrl.sv
// Presents one eligible interrupt file to the hart, waits for claim, pulses a clear back.
// Optional feature: define AIA_CLAIM_PREEMPT_EN to let higher-priority classes replace a presentation.
module aia_intp_file_claim_ctrl
  import aia_pkg::*;
#(
  parameter int unsigned NrVSIntpFiles = 0,
  parameter int unsigned NrIntpFiles   = 2 + NrVSIntpFiles,
  parameter int unsigned NrSourcesW    = 5,
  parameter int unsigned FileW         = file_w(NrIntpFiles)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NrIntpFiles-1:0]            file_pend_i,
  input  logic [NrIntpFiles*NrSourcesW-1:0] file_id_i,
  input  logic [NrIntpFiles-1:0]            file_en_i,
  output logic                              irq_valid_o,
  output logic [FileW-1:0]                  irq_file_o,
  output logic [NrSourcesW-1:0]             irq_id_o,
  input  logic                              claim_i,
  output logic [NrIntpFiles-1:0]            claim_file_o,
  output logic [NrSourcesW-1:0]             claim_id_o
);

  logic [NrIntpFiles-1:0] elig;
  logic                   vs_valid;
  logic [FileW-1:0]       vs_file;
  logic                   win_valid;
  logic [FileW-1:0]       win_file;
  logic [NrSourcesW-1:0]  win_id;
  logic                   lat_elig;
  logic [NrSourcesW-1:0]  lat_id;
  logic                   withdraw;
  logic                   preempt;
  logic                   claim_take;

  state_e                 state_q, state_d;
  logic [FileW-1:0]       file_q, file_d;
  logic [NrSourcesW-1:0]  id_q, id_d;

  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NrIntpFiles; k++) begin
      elig[k] = file_pend_i[k] & file_en_i[k] & (|file_id_i[k*NrSourcesW +: NrSourcesW]);
    end
  end

  // Fixed priority M > S, VS falls back to the round-robin pick.
  always_comb begin
    win_valid = 1'b1;
    win_file  = FileW'(M_FILE);
    if (!elig[M_FILE]) begin
      if (elig[S_FILE]) begin
        win_file = FileW'(S_FILE);
      end else begin
        win_valid = vs_valid;
        win_file  = vs_file;
      end
    end
    win_id = file_id_i[32'(win_file)*NrSourcesW +: NrSourcesW];
  end

  assign lat_elig = elig[file_q];
  assign lat_id   = file_id_i[32'(file_q)*NrSourcesW +: NrSourcesW];
  assign withdraw = !lat_elig || (lat_id != id_q);

`ifdef AIA_CLAIM_PREEMPT_EN
  assign preempt = win_valid && (file_class(32'(win_file)) < file_class(32'(file_q)));
`else
  assign preempt = 1'b0;
`endif

  if (NrVSIntpFiles > 0) begin : g_vs
    localparam int unsigned PtrW = file_w(NrVSIntpFiles);

    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0] pick_idx;
    logic            pick_valid;

    aia_vs_rr_sel #(
      .NrVS (NrVSIntpFiles),
      .PtrW (PtrW)
    ) u_vs_rr_sel (
      .vs_elig    (elig[NrIntpFiles-1:VS_BASE]),
      .ptr        (rr_ptr_q),
      .pick_valid (pick_valid),
      .pick_idx   (pick_idx)
    );

    assign vs_valid = pick_valid;
    assign vs_file  = FileW'(VS_BASE) + FileW'(pick_idx);

    // Only a claimed VS file advances fairness; withdrawals leave the pointer alone.
    always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (claim_take && (32'(file_q) >= VS_BASE)) begin
        if (32'(file_q) - VS_BASE + 1 >= NrVSIntpFiles) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = PtrW'(32'(file_q) - VS_BASE + 1);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end else begin : g_no_vs
    logic unused_claim_take;
    assign unused_claim_take = claim_take;
    assign vs_valid          = 1'b0;
    assign vs_file           = '0;
  end

  always_comb begin
    state_d    = state_q;
    file_d     = file_q;
    id_d       = id_q;
    claim_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StPresent;
          file_d  = win_file;
          id_d    = win_id;
        end
      end
      StPresent: begin
        if (claim_i) begin
          state_d    = StClaim;
          claim_take = 1'b1;
        end else if (preempt) begin
          file_d = win_file;
          id_d   = win_id;
        end else if (withdraw) begin
          state_d = StIdle;
        end
      end
      // No arbitration while the clear is in flight, so a stale id cannot be re-presented.
      StClaim: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      file_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      file_q  <= file_d;
      id_q    <= id_d;
    end
  end

  assign irq_valid_o = (state_q == StPresent);
  assign irq_file_o  = file_q;
  assign irq_id_o    = id_q;

  always_comb begin
    claim_file_o = '0;
    claim_id_o   = '0;
    if (state_q == StClaim) begin
      claim_file_o[file_q] = 1'b1;
      claim_id_o           = id_q;
    end
  end

endmodule

// File: tb/tb_aia_intp_file_claim_ctrl.sv
// Bench for aia_intp_file_claim_ctrl with two VS files; directed scenarios plus a randomized run.
module tb_aia_intp_file_claim_ctrl;

  localparam int NV = 2;
  localparam int NF = 2 + NV;
  localparam int W  = 5;
  localparam int FW = 2;

  logic            clk_i;
  logic            rst_i;
  logic [NF-1:0]   file_pend_i;
  logic [NF*W-1:0] file_id_i;
  logic [NF-1:0]   file_en_i;
  logic            irq_valid_o;
  logic [FW-1:0]   irq_file_o;
  logic [W-1:0]    irq_id_o;
  logic            claim_i;
  logic [NF-1:0]   claim_file_o;
  logic [W-1:0]    claim_id_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_present;
  bit m_clear;
  int m_file;
  int m_id;
  int m_ptr;

  aia_intp_file_claim_ctrl #(
    .NrVSIntpFiles (NV)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .file_pend_i  (file_pend_i),
    .file_id_i    (file_id_i),
    .file_en_i    (file_en_i),
    .irq_valid_o  (irq_valid_o),
    .irq_file_o   (irq_file_o),
    .irq_id_o     (irq_id_o),
    .claim_i      (claim_i),
    .claim_file_o (claim_file_o),
    .claim_id_o   (claim_id_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic int get_id(int k);
    return int'(file_id_i[k*W +: W]);
  endfunction

  function automatic bit is_elig(int k);
    return file_pend_i[k] && file_en_i[k] && (get_id(k) != 0);
  endfunction

  function automatic int cls(int f);
    return (f < 2) ? f : 2;
  endfunction

  // Winner by the priority rules: M, then S, then VS round-robin from m_ptr; -1 if none.
  function automatic int pick();
    if (is_elig(0)) return 0;
    if (is_elig(1)) return 1;
    for (int i = 0; i < NV; i++) begin
      if (is_elig(2 + (m_ptr + i) % NV)) return 2 + (m_ptr + i) % NV;
    end
    return -1;
  endfunction

  task automatic mdl_step();
    int p;
    p = pick();
    if (rst_i) begin
      m_present = 0; m_clear = 0; m_file = 0; m_id = 0; m_ptr = 0;
    end else if (m_clear) begin
      m_clear = 0;
    end else if (m_present) begin
      if (claim_i) begin
        m_present = 0;
        m_clear   = 1;
        if (m_file >= 2) m_ptr = (m_file - 2 + 1) % NV;
`ifdef AIA_CLAIM_PREEMPT_EN
      end else if (p >= 0 && cls(p) < cls(m_file)) begin
        m_file = p;
        m_id   = get_id(p);
`endif
      end else if (!is_elig(m_file) || get_id(m_file) != m_id) begin
        m_present = 0;
      end
    end else if (p >= 0) begin
      m_present = 1;
      m_file    = p;
      m_id      = get_id(p);
    end
  endtask

  task automatic tick();
    mdl_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_file(input int k, input bit p, input bit e, input int id);
    file_pend_i[k]     = p;
    file_en_i[k]       = e;
    file_id_i[k*W +: W] = W'(id);
  endtask

  task automatic go_idle();
    file_pend_i = '0;
    file_en_i   = '0;
    file_id_i   = '0;
    claim_i     = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    file_pend_i = '1;
    file_en_i   = '1;
    for (int k = 0; k < NF; k++) file_id_i[k*W +: W] = W'(9 + k);
    claim_i     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({irq_valid_o, irq_file_o, irq_id_o, claim_file_o, claim_id_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got valid=%0b file=%0d id=%0d cf=%b cid=%0d want all 0",
                 c, irq_valid_o, irq_file_o, irq_id_o, claim_file_o, claim_id_o);
      end
    end
    rst_i   = 1'b0;
    claim_i = 1'b0;
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_file_o !== 2'd0 || irq_id_o !== 5'd9) begin
      errors++;
      $display("FAIL reset_release: got valid=%0b file=%0d id=%0d want 1/0/9",
               irq_valid_o, irq_file_o, irq_id_o);
    end
  endtask

  task automatic test_priority();
    go_idle();
    set_file(0, 1, 1, 3);
    set_file(1, 1, 1, 7);
    set_file(2, 1, 1, 2);
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_file_o !== 2'd0 || irq_id_o !== 5'd3) begin
      errors++;
      $display("FAIL priority_present: got valid=%0b file=%0d id=%0d want 1/0/3",
               irq_valid_o, irq_file_o, irq_id_o);
    end
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    checks++;
    if (claim_file_o !== 4'b0001 || claim_id_o !== 5'd3 || irq_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL priority_clear: got cf=%b cid=%0d valid=%0b want 0001/3/0",
               claim_file_o, claim_id_o, irq_valid_o);
    end
    tick();
    checks++;
    if (claim_file_o !== 4'b0000) begin
      errors++;
      $display("FAIL priority_clear_width: got cf=%b want 0000", claim_file_o);
    end
  endtask

  task automatic test_round_robin();
    int n;
    go_idle();
    set_file(2, 1, 1, 4);
    set_file(3, 1, 1, 6);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (irq_valid_o !== 1'b1 && n < 6) begin
        tick();
        n++;
      end
      checks++;
      if (irq_valid_o !== 1'b1 || irq_file_o !== 2'(2 + i % 2)) begin
        errors++;
        $display("FAIL rr_file%0d: got valid=%0b file=%0d want 1/%0d",
                 i, irq_valid_o, irq_file_o, 2 + i % 2);
      end
      claim_i = 1'b1;
      tick();
      claim_i = 1'b0;
      checks++;
      if (claim_file_o !== 4'(1 << (2 + i % 2)) || claim_id_o !== 5'((i % 2) ? 6 : 4)) begin
        errors++;
        $display("FAIL rr_clear%0d: got cf=%b cid=%0d want %b/%0d", i, claim_file_o,
                 claim_id_o, 4'(1 << (2 + i % 2)), (i % 2) ? 6 : 4);
      end
      tick();
    end
  endtask

  task automatic test_withdraw();
    go_idle();
    set_file(1, 1, 1, 5);
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_file_o !== 2'd1 || irq_id_o !== 5'd5) begin
      errors++;
      $display("FAIL withdraw_present: got valid=%0b file=%0d id=%0d want 1/1/5",
               irq_valid_o, irq_file_o, irq_id_o);
    end
    file_en_i[1] = 1'b0;
    tick();
    checks++;
    if (irq_valid_o !== 1'b0 || claim_file_o !== 4'b0000) begin
      errors++;
      $display("FAIL withdraw_drop: got valid=%0b cf=%b want 0/0000", irq_valid_o, claim_file_o);
    end
    tick();
    checks++;
    if (claim_file_o !== 4'b0000) begin
      errors++;
      $display("FAIL withdraw_noclear: got cf=%b want 0000", claim_file_o);
    end
    file_en_i[1] = 1'b1;
    tick();
    file_en_i[1] = 1'b0;
    claim_i      = 1'b1;
    tick();
    claim_i = 1'b0;
    checks++;
    if (claim_file_o !== 4'b0010 || claim_id_o !== 5'd5) begin
      errors++;
      $display("FAIL withdraw_claim_wins: got cf=%b cid=%0d want 0010/5", claim_file_o, claim_id_o);
    end
    tick();
  endtask

  task automatic test_preempt();
    go_idle();
    set_file(1, 1, 1, 5);
    tick();
    set_file(0, 1, 1, 1);
    tick();
`ifdef AIA_CLAIM_PREEMPT_EN
    checks++;
    if (irq_valid_o !== 1'b1 || irq_file_o !== 2'd0 || irq_id_o !== 5'd1) begin
      errors++;
      $display("FAIL preempt_replace: got valid=%0b file=%0d id=%0d want 1/0/1",
               irq_valid_o, irq_file_o, irq_id_o);
    end
`else
    checks++;
    if (irq_valid_o !== 1'b1 || irq_file_o !== 2'd1 || irq_id_o !== 5'd5) begin
      errors++;
      $display("FAIL preempt_hold: got valid=%0b file=%0d id=%0d want 1/1/5",
               irq_valid_o, irq_file_o, irq_id_o);
    end
`endif
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    checks++;
`ifdef AIA_CLAIM_PREEMPT_EN
    if (claim_file_o !== 4'b0001 || claim_id_o !== 5'd1) begin
      errors++;
      $display("FAIL preempt_clear: got cf=%b cid=%0d want 0001/1", claim_file_o, claim_id_o);
    end
`else
    if (claim_file_o !== 4'b0010 || claim_id_o !== 5'd5) begin
      errors++;
      $display("FAIL preempt_clear: got cf=%b cid=%0d want 0010/5", claim_file_o, claim_id_o);
    end
`endif
    tick();
  endtask

  task automatic test_spurious_claim();
    go_idle();
    claim_i = 1'b1;
    tick();
    tick();
    claim_i = 1'b0;
    checks++;
    if (claim_file_o !== 4'b0000 || irq_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_claim: got cf=%b valid=%0b want 0000/0", claim_file_o, irq_valid_o);
    end
  endtask

  task automatic test_random();
    logic [NF-1:0] exp_cf;
    logic [W-1:0]  exp_cid;
    go_idle();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NF; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          set_file(k, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 31)));
        end
      end
      claim_i = 1'($urandom_range(0, 2) == 0);
      tick();
      exp_cf  = m_clear ? 4'(1 << m_file) : 4'b0000;
      exp_cid = m_clear ? 5'(m_id) : 5'd0;
      checks++;
      if (irq_valid_o !== m_present
          || (m_present && (irq_file_o !== 2'(m_file) || irq_id_o !== 5'(m_id)))
          || claim_file_o !== exp_cf || claim_id_o !== exp_cid) begin
        errors++;
        $display("FAIL random_cyc%0d: got v=%0b f=%0d id=%0d cf=%b cid=%0d want v=%0b f=%0d id=%0d cf=%b cid=%0d",
                 c, irq_valid_o, irq_file_o, irq_id_o, claim_file_o, claim_id_o,
                 m_present, m_file, m_id, exp_cf, exp_cid);
      end
    end
    claim_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    claim_i     = 1'b0;
    file_pend_i = '0;
    file_en_i   = '0;
    file_id_i   = '0;
    test_reset();
    test_priority();
    test_round_robin();
    test_withdraw();
    test_preempt();
    test_spurious_claim();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
